// File: rtl/fetch_stage.sv
// Instruction-fetch stage with the F/D pipeline latch.
// Holds the fetch PC, drives the instruction-memory address, latches the
// fetched word into F/D, and applies stalls and branch/jump redirects.
// Fetch and bubble performance counters are kept alongside.
module fetch_stage #(
    parameter int          ADDR_WIDTH = 12,
    parameter logic [31:0] RESET_PC   = 32'd0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  redirect,
    input  logic [31:0]           redirect_pc,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [31:0]           imem_data,
    output logic [31:0]           pc,
    output logic [31:0]           fd_instruction,
    output logic [31:0]           fd_pc,
    output logic [31:0]           fd_pc_plus1,
    output logic                  fd_valid,
    output logic [31:0]           fetch_count,
    output logic [31:0]           bubble_count
);

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetchState_t;

    fetchState_t r_state;
    fetchState_t w_nextState;

    logic [31:0] r_pc;
    logic [31:0] r_fdInstruction;
    logic [31:0] r_fdPc;
    logic [31:0] r_fdPcPlus1;
    logic        r_fdValid;
    logic [31:0] r_fetchCount;
    logic [31:0] r_bubbleCount;

    logic [31:0] w_pcPlus1;
    logic        w_loadFetch;
    logic        w_loadBubble;
    logic        w_loadRedirect;

    // The incremented PC feeds both the next fetch PC and the registered link value.
    assign w_pcPlus1 = r_pc + 32'd1;

    // State register; reset always returns to BOOT, even mid-stall or mid-redirect.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and per-edge action selection: redirect beats stall beats normal fetch.
    always_comb begin
        w_nextState    = r_state;
        w_loadFetch    = 1'b0;
        w_loadBubble   = 1'b0;
        w_loadRedirect = 1'b0;
        case (r_state)
            BOOT: begin
                w_nextState    = RUN;
                w_loadBubble   = 1'b1;
                w_loadRedirect = redirect;
            end
            RUN: begin
                if (redirect) begin
                    w_loadBubble   = 1'b1;
                    w_loadRedirect = 1'b1;
                end else if (!stall) begin
                    w_loadFetch = 1'b1;
                end
            end
            default: begin
                w_nextState = BOOT;
            end
        endcase
    end

    // PC, F/D latch and counters; a stalled RUN cycle leaves every register untouched.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc            <= RESET_PC;
            r_fdInstruction <= 32'd0;
            r_fdPc          <= 32'd0;
            r_fdPcPlus1     <= 32'd0;
            r_fdValid       <= 1'b0;
            r_fetchCount    <= 32'd0;
            r_bubbleCount   <= 32'd0;
        end else begin
            if (w_loadRedirect) begin
                r_pc <= redirect_pc;
            end else if (w_loadFetch) begin
                r_pc <= w_pcPlus1;
            end

            if (w_loadBubble) begin
                r_fdInstruction <= 32'd0;
                r_fdPc          <= 32'd0;
                r_fdPcPlus1     <= 32'd0;
                r_fdValid       <= 1'b0;
                r_bubbleCount   <= r_bubbleCount + 32'd1;
            end else if (w_loadFetch) begin
                r_fdInstruction <= imem_data;
                r_fdPc          <= r_pc;
                r_fdPcPlus1     <= w_pcPlus1;
                r_fdValid       <= 1'b1;
                r_fetchCount    <= r_fetchCount + 32'd1;
            end
        end
    end

    assign imem_addr      = r_pc[ADDR_WIDTH-1:0];
    assign pc             = r_pc;
    assign fd_instruction = r_fdInstruction;
    assign fd_pc          = r_fdPc;
    assign fd_pc_plus1    = r_fdPcPlus1;
    assign fd_valid       = r_fdValid;
    assign fetch_count    = r_fetchCount;
    assign bubble_count   = r_bubbleCount;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage.
// The instruction memory is modelled as imem[k] = 32'h1000_0000 + k.
module tb_fetch_stage;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [11:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] pc;
    logic [31:0] fd_instruction;
    logic [31:0] fd_pc;
    logic [31:0] fd_pc_plus1;
    logic        fd_valid;
    logic [31:0] fetch_count;
    logic [31:0] bubble_count;

    int nCompared;
    int nMismatched;

    fetch_stage #(
        .ADDR_WIDTH(12),
        .RESET_PC  (32'd0)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .pc            (pc),
        .fd_instruction(fd_instruction),
        .fd_pc         (fd_pc),
        .fd_pc_plus1   (fd_pc_plus1),
        .fd_valid      (fd_valid),
        .fetch_count   (fetch_count),
        .bubble_count  (bubble_count)
    );

    // Free-running clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Combinational instruction memory with a recognisable pattern.
    assign imem_data = 32'h1000_0000 + {20'd0, imem_addr};

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Reset values after a reset edge, then the BOOT edge.
    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        step();
        step();
        nCompared++; if (pc !== 32'd0) begin nMismatched++; $display("[TB] FAIL reset_pc got %h exp %h", pc, 32'd0); end
        nCompared++; if (fd_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_valid got %b exp 0", fd_valid); end
        nCompared++; if (fd_instruction !== 32'd0) begin nMismatched++; $display("[TB] FAIL reset_instr got %h exp 0", fd_instruction); end
        nCompared++; if (fetch_count !== 32'd0) begin nMismatched++; $display("[TB] FAIL reset_fetch got %0d exp 0", fetch_count); end
        nCompared++; if (bubble_count !== 32'd0) begin nMismatched++; $display("[TB] FAIL reset_bubble got %0d exp 0", bubble_count); end
        reset = 1'b0;
        step();
        nCompared++; if (fd_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL boot_valid got %b exp 0", fd_valid); end
        nCompared++; if (bubble_count !== 32'd1) begin nMismatched++; $display("[TB] FAIL boot_bubble got %0d exp 1", bubble_count); end
        nCompared++; if (pc !== 32'd0) begin nMismatched++; $display("[TB] FAIL boot_pc got %h exp 0", pc); end
    endtask

    // First real fetch, then run until pc == 4.
    task automatic test_run();
        step();
        nCompared++; if (fd_instruction !== 32'h1000_0000) begin nMismatched++; $display("[TB] FAIL run_instr got %h exp 10000000", fd_instruction); end
        nCompared++; if (fd_pc !== 32'd0) begin nMismatched++; $display("[TB] FAIL run_fdpc got %h exp 0", fd_pc); end
        nCompared++; if (fd_pc_plus1 !== 32'd1) begin nMismatched++; $display("[TB] FAIL run_plus1 got %h exp 1", fd_pc_plus1); end
        nCompared++; if (pc !== 32'd1) begin nMismatched++; $display("[TB] FAIL run_pc got %h exp 1", pc); end
        nCompared++; if (fd_valid !== 1'b1) begin nMismatched++; $display("[TB] FAIL run_valid got %b exp 1", fd_valid); end
        for (int i = 0; i < 3; i++) step();
        nCompared++; if (pc !== 32'd4) begin nMismatched++; $display("[TB] FAIL run4_pc got %h exp 4", pc); end
        nCompared++; if (fd_instruction !== 32'h1000_0003) begin nMismatched++; $display("[TB] FAIL run4_instr got %h exp 10000003", fd_instruction); end
        nCompared++; if (fetch_count !== 32'd4) begin nMismatched++; $display("[TB] FAIL run4_fetch got %0d exp 4", fetch_count); end
    endtask

    // Three stalled cycles hold everything; the release edge fetches pc 4.
    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            nCompared++; if (pc !== 32'd4) begin nMismatched++; $display("[TB] FAIL stall_pc[%0d] got %h exp 4", i, pc); end
            nCompared++; if (fd_pc !== 32'd3) begin nMismatched++; $display("[TB] FAIL stall_fdpc[%0d] got %h exp 3", i, fd_pc); end
            nCompared++; if (fetch_count !== 32'd4) begin nMismatched++; $display("[TB] FAIL stall_fetch[%0d] got %0d exp 4", i, fetch_count); end
            nCompared++; if (bubble_count !== 32'd1) begin nMismatched++; $display("[TB] FAIL stall_bubble[%0d] got %0d exp 1", i, bubble_count); end
        end
        stall = 1'b0;
        step();
        nCompared++; if (fd_pc !== 32'd4) begin nMismatched++; $display("[TB] FAIL release_fdpc got %h exp 4", fd_pc); end
        nCompared++; if (pc !== 32'd5) begin nMismatched++; $display("[TB] FAIL release_pc got %h exp 5", pc); end
        nCompared++; if (fetch_count !== 32'd5) begin nMismatched++; $display("[TB] FAIL release_fetch got %0d exp 5", fetch_count); end
    endtask

    // Redirect at pc 7 to 100: one bubble, then imem[100].
    task automatic test_redirect();
        step();
        step();
        nCompared++; if (pc !== 32'd7) begin nMismatched++; $display("[TB] FAIL pre_redirect_pc got %h exp 7", pc); end
        redirect = 1'b1; redirect_pc = 32'd100;
        step();
        redirect = 1'b0;
        nCompared++; if (pc !== 32'd100) begin nMismatched++; $display("[TB] FAIL redirect_pc got %0d exp 100", pc); end
        nCompared++; if (fd_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL redirect_valid got %b exp 0", fd_valid); end
        nCompared++; if (fd_instruction !== 32'd0) begin nMismatched++; $display("[TB] FAIL redirect_instr got %h exp 0", fd_instruction); end
        nCompared++; if (fd_pc_plus1 !== 32'd0) begin nMismatched++; $display("[TB] FAIL redirect_plus1 got %h exp 0", fd_pc_plus1); end
        nCompared++; if (bubble_count !== 32'd2) begin nMismatched++; $display("[TB] FAIL redirect_bubble got %0d exp 2", bubble_count); end
        nCompared++; if (fetch_count !== 32'd7) begin nMismatched++; $display("[TB] FAIL redirect_fetch got %0d exp 7", fetch_count); end
        step();
        nCompared++; if (fd_pc !== 32'd100) begin nMismatched++; $display("[TB] FAIL target_fdpc got %0d exp 100", fd_pc); end
        nCompared++; if (fd_instruction !== 32'h1000_0064) begin nMismatched++; $display("[TB] FAIL target_instr got %h exp 10000064", fd_instruction); end
        nCompared++; if (fd_pc_plus1 !== 32'd101) begin nMismatched++; $display("[TB] FAIL target_plus1 got %0d exp 101", fd_pc_plus1); end
    endtask

    // Redirect with stall also high: the redirect must win.
    task automatic test_redirect_over_stall();
        redirect = 1'b1; redirect_pc = 32'd9;
        step();
        nCompared++; if (pc !== 32'd9) begin nMismatched++; $display("[TB] FAIL setup9_pc got %0d exp 9", pc); end
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'd20;
        step();
        stall = 1'b0; redirect = 1'b0;
        nCompared++; if (pc !== 32'd20) begin nMismatched++; $display("[TB] FAIL rs_pc got %0d exp 20", pc); end
        nCompared++; if (fd_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL rs_valid got %b exp 0", fd_valid); end
        nCompared++; if (fd_pc !== 32'd0) begin nMismatched++; $display("[TB] FAIL rs_fdpc got %h exp 0", fd_pc); end
        nCompared++; if (bubble_count !== 32'd4) begin nMismatched++; $display("[TB] FAIL rs_bubble got %0d exp 4", bubble_count); end
        nCompared++; if (fetch_count !== 32'd8) begin nMismatched++; $display("[TB] FAIL rs_fetch got %0d exp 8", fetch_count); end
    endtask

    // PC wrap at the top of the address space and imem_addr aliasing.
    task automatic test_wrap();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        step();
        redirect = 1'b0;
        nCompared++; if (imem_addr !== 12'hFFF) begin nMismatched++; $display("[TB] FAIL wrap_addr got %h exp fff", imem_addr); end
        step();
        nCompared++; if (pc !== 32'd0) begin nMismatched++; $display("[TB] FAIL wrap_pc got %h exp 0", pc); end
        nCompared++; if (fd_pc_plus1 !== 32'd0) begin nMismatched++; $display("[TB] FAIL wrap_plus1 got %h exp 0", fd_pc_plus1); end
        nCompared++; if (fd_pc !== 32'hFFFF_FFFF) begin nMismatched++; $display("[TB] FAIL wrap_fdpc got %h exp ffffffff", fd_pc); end
        nCompared++; if (fd_instruction !== 32'h1000_0FFF) begin nMismatched++; $display("[TB] FAIL wrap_instr got %h exp 10000fff", fd_instruction); end
    endtask

    // Reset asserted while stalled with fetch_count 6; BOOT must follow.
    task automatic test_reset_mid_stall();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 7; i++) step();
        nCompared++; if (fetch_count !== 32'd6) begin nMismatched++; $display("[TB] FAIL pre_reset_fetch got %0d exp 6", fetch_count); end
        stall = 1'b1;
        step();
        reset = 1'b1;
        step();
        nCompared++; if (pc !== 32'd0) begin nMismatched++; $display("[TB] FAIL mid_reset_pc got %h exp 0", pc); end
        nCompared++; if (fd_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL mid_reset_valid got %b exp 0", fd_valid); end
        nCompared++; if (fd_pc !== 32'd0) begin nMismatched++; $display("[TB] FAIL mid_reset_fdpc got %h exp 0", fd_pc); end
        nCompared++; if (fd_pc_plus1 !== 32'd0) begin nMismatched++; $display("[TB] FAIL mid_reset_plus1 got %h exp 0", fd_pc_plus1); end
        nCompared++; if (fetch_count !== 32'd0) begin nMismatched++; $display("[TB] FAIL mid_reset_fetch got %0d exp 0", fetch_count); end
        nCompared++; if (bubble_count !== 32'd0) begin nMismatched++; $display("[TB] FAIL mid_reset_bubble got %0d exp 0", bubble_count); end
        reset = 1'b0; stall = 1'b0;
        step();
        nCompared++; if (fd_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL post_reset_boot_valid got %b exp 0", fd_valid); end
        nCompared++; if (pc !== 32'd0) begin nMismatched++; $display("[TB] FAIL post_reset_boot_pc got %h exp 0", pc); end
        nCompared++; if (bubble_count !== 32'd1) begin nMismatched++; $display("[TB] FAIL post_reset_boot_bubble got %0d exp 1", bubble_count); end
    endtask

    // Redirect sampled in BOOT: load target, go to RUN, count one bubble.
    task automatic test_boot_redirect();
        reset = 1'b1;
        step();
        reset = 1'b0; redirect = 1'b1; redirect_pc = 32'd50;
        step();
        redirect = 1'b0;
        nCompared++; if (pc !== 32'd50) begin nMismatched++; $display("[TB] FAIL boot_redir_pc got %0d exp 50", pc); end
        nCompared++; if (bubble_count !== 32'd1) begin nMismatched++; $display("[TB] FAIL boot_redir_bubble got %0d exp 1", bubble_count); end
        step();
        nCompared++; if (fd_instruction !== 32'h1000_0032) begin nMismatched++; $display("[TB] FAIL boot_redir_instr got %h exp 10000032", fd_instruction); end
        nCompared++; if (fd_valid !== 1'b1) begin nMismatched++; $display("[TB] FAIL boot_redir_valid got %b exp 1", fd_valid); end
        nCompared++; if (pc !== 32'd51) begin nMismatched++; $display("[TB] FAIL boot_redir_next_pc got %0d exp 51", pc); end
    endtask

    // Scenario sequence and summary.
    initial begin
        nCompared   = 0;
        nMismatched = 0;
        reset       = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        test_reset();
        test_run();
        test_stall();
        test_redirect();
        test_redirect_over_stall();
        test_wrap();
        test_reset_mid_stall();
        test_boot_redirect();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
